// File: rtl/tablet_pkg.sv
// Shared types and constants for the tablet-filling line controller.
package tablet_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned STATE_W = 3;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Two-digit BCD value: bottle count and per-bottle target.
  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_SWAP  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // A usable target has two legal BCD digits and is not zero.
  function automatic logic target_ok(input bcd2_t t);
    return (t.tens <= BCD_MAX) && (t.ones <= BCD_MAX) && (t != '0);
  endfunction

  // Two-digit BCD increment; ones wraps 9->0 and carries into tens.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == BCD_MAX) begin
      r.ones = '0;
      r.tens = (v.tens == BCD_MAX) ? '0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser; optional rising-edge detector on the synchronised level.
module edge_sync #(
  parameter bit RISE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic s1;
  logic s2;

  // Metastability guard for the asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  generate
    if (RISE) begin : g_rise
      logic s3;

      // Delayed copy of the synchronised level for edge detection.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) s3 <= 1'b0;
        else       s3 <= s2;
      end

      assign dout = s2 & ~s3;
    end else begin : g_level
      assign dout = s2;
    end
  endgenerate

endmodule

// File: rtl/tablet_fill_ctrl.sv
// Bottle-fill sequencer: counts tablets per bottle, swaps bottles, ends after a batch quota.
module tablet_fill_ctrl
  import tablet_pkg::*;
#(
  parameter int unsigned MAX_BOTTLES = 10,
  parameter int unsigned SWAP_CYC    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       pill,
  input  logic [3:0] target_tens,
  input  logic [3:0] target_ones,
  output logic       count_en,
  output logic       allow_start,
  output logic       stop,
  output logic       over,
  output logic       valve_open,
  output logic       bottle_swap,
  output logic [3:0] bottle_tens,
  output logic [3:0] bottle_ones,
  output logic [3:0] bottles_done,
  output logic       cfg_err,
  output logic [2:0] state
);

  localparam int unsigned     SWAP_W    = (SWAP_CYC > 1) ? $clog2(SWAP_CYC) : 1;
  localparam logic [SWAP_W-1:0] SWAP_LAST = SWAP_W'(SWAP_CYC - 1);
  localparam logic [3:0]      MAX_B     = 4'(MAX_BOTTLES);

  logic start_rise;
  logic stop_lvl;
  logic pill_rise;

  state_t            state_q, state_d;
  bcd2_t             cnt_q, cnt_d;
  bcd2_t             tgt_q, tgt_d;
  bcd2_t             tgt_in;
  logic [3:0]        done_q, done_d;
  logic [SWAP_W-1:0] swap_q, swap_d;
  logic              en_d;
  logic              err_d;

  edge_sync #(.RISE(1'b1)) u_start_sync (.clk(clk), .reset(reset), .din(start_btn), .dout(start_rise));
  edge_sync #(.RISE(1'b0)) u_stop_sync  (.clk(clk), .reset(reset), .din(stop_btn),  .dout(stop_lvl));
  edge_sync #(.RISE(1'b1)) u_pill_sync  (.clk(clk), .reset(reset), .din(pill),      .dout(pill_rise));

  assign tgt_in = '{tens: target_tens, ones: target_ones};

  // Next-state, bottle counter, batch counter and swap timer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    done_d  = done_q;
    swap_d  = swap_q;
    en_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_rise) begin
          tgt_d = tgt_in;
          if (!target_ok(tgt_in)) begin
            err_d = 1'b1;
          end else begin
            cnt_d   = '0;
            done_d  = '0;
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (cnt_q == tgt_q) begin
          state_d = ST_SWAP;
          done_d  = done_q + 4'd1;
          cnt_d   = '0;
          swap_d  = SWAP_LAST;
        end else begin
          if (pill_rise) begin
            en_d  = 1'b1;
            cnt_d = bcd_inc(cnt_q);
          end
          // A tablet that completes the bottle wins over a pause request.
          if (stop_lvl && (cnt_d != tgt_q)) state_d = ST_PAUSE;
        end
      end
      ST_SWAP: begin
        if (swap_q == '0) begin
          if (done_q == MAX_B) state_d = ST_DONE;
          else if (stop_lvl)   state_d = ST_PAUSE;
          else                 state_d = ST_FILL;
        end else begin
          swap_d = swap_q - SWAP_W'(1);
        end
      end
      ST_PAUSE: begin
        if (!stop_lvl) state_d = ST_FILL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; indicators follow the upcoming state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tgt_q       <= '0;
      done_q      <= '0;
      swap_q      <= '0;
      count_en    <= 1'b0;
      cfg_err     <= 1'b0;
      allow_start <= 1'b0;
      stop        <= 1'b0;
      over        <= 1'b0;
      valve_open  <= 1'b0;
      bottle_swap <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      done_q      <= done_d;
      swap_q      <= swap_d;
      count_en    <= en_d;
      cfg_err     <= err_d;
      allow_start <= (state_d == ST_FILL) || (state_d == ST_SWAP) || (state_d == ST_PAUSE);
      stop        <= (state_d == ST_PAUSE);
      over        <= (state_d == ST_DONE);
      valve_open  <= (state_d == ST_FILL);
      bottle_swap <= (state_d == ST_SWAP);
    end
  end

  assign bottle_tens  = cnt_q.tens;
  assign bottle_ones  = cnt_q.ones;
  assign bottles_done = done_q;
  assign state        = state_q;

endmodule

// File: tb/tb_tablet_fill_ctrl.sv
// Bench for tablet_fill_ctrl: decimal reference model plus directed scenarios.
module tb_tablet_fill_ctrl;

  localparam int MAXB  = 2;
  localparam int SWAPC = 4;
  localparam int M_IDLE = 0, M_FILL = 1, M_SWAP = 2, M_PAUSE = 3, M_DONE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       pill = 1'b0;
  logic [3:0] target_tens = 4'd0;
  logic [3:0] target_ones = 4'd0;
  logic       count_en, allow_start, stop, over, valve_open, bottle_swap, cfg_err;
  logic [3:0] bottle_tens, bottle_ones, bottles_done;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  tablet_fill_ctrl #(.MAX_BOTTLES(MAXB), .SWAP_CYC(SWAPC)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .stop_btn(stop_btn), .pill(pill),
    .target_tens(target_tens), .target_ones(target_ones),
    .count_en(count_en), .allow_start(allow_start), .stop(stop), .over(over),
    .valve_open(valve_open), .bottle_swap(bottle_swap), .bottle_tens(bottle_tens),
    .bottle_ones(bottle_ones), .bottles_done(bottles_done), .cfg_err(cfg_err), .state(state)
  );

  always #5 clk = ~clk;

  logic [21:0] dut_vec;
  assign dut_vec = {count_en, allow_start, stop, over, valve_open, bottle_swap,
                    bottle_tens, bottle_ones, bottles_done, cfg_err, state};

  // Reference model: integer tablet count, mode number, inputs seen two clocks late.
  int m_mode = 0, m_cnt = 0, m_tgt = 0, m_bot = 0, m_swap = 0;
  bit m_en = 0, m_err = 0;
  bit p0 = 0, p1 = 0, p2 = 0, s0 = 0, s1 = 0, s2 = 0, q0 = 0, q1 = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_cnt = 0; m_tgt = 0; m_bot = 0; m_swap = 0; m_en = 0; m_err = 0;
      p0 = 0; p1 = 0; p2 = 0; s0 = 0; s1 = 0; s2 = 0; q0 = 0; q1 = 0;
    end else begin
      bit prise, srise, slvl;
      prise = p1 && !p2;
      srise = s1 && !s2;
      slvl  = q1;
      m_en = 0;
      m_err = 0;
      case (m_mode)
        M_IDLE, M_DONE: if (srise) begin
          if (target_tens > 9 || target_ones > 9 || (target_tens == 0 && target_ones == 0)) m_err = 1;
          else begin
            m_tgt = int'(target_tens) * 10 + int'(target_ones);
            m_cnt = 0; m_bot = 0; m_mode = M_FILL;
          end
        end
        M_FILL: if (m_cnt == m_tgt) begin
          m_mode = M_SWAP; m_bot = m_bot + 1; m_cnt = 0; m_swap = SWAPC;
        end else begin
          if (prise) begin m_cnt = m_cnt + 1; m_en = 1; end
          if (slvl && m_cnt != m_tgt) m_mode = M_PAUSE;
        end
        M_SWAP: begin
          m_swap = m_swap - 1;
          if (m_swap == 0) m_mode = (m_bot == MAXB) ? M_DONE : (slvl ? M_PAUSE : M_FILL);
        end
        M_PAUSE: if (!slvl) m_mode = M_FILL;
        default: m_mode = M_IDLE;
      endcase
      p2 = p1; p1 = p0; p0 = pill;
      s2 = s1; s1 = s0; s0 = start_btn;
      q1 = q0; q0 = stop_btn;
    end
  end

  function automatic logic [21:0] exp_vec();
    logic a, st, ov, va, sw;
    a  = (m_mode == M_FILL) || (m_mode == M_SWAP) || (m_mode == M_PAUSE);
    st = (m_mode == M_PAUSE);
    ov = (m_mode == M_DONE);
    va = (m_mode == M_FILL);
    sw = (m_mode == M_SWAP);
    return {m_en, a, st, ov, va, sw, 4'(m_cnt / 10), 4'(m_cnt % 10), 4'(m_bot), m_err, 3'(m_mode)};
  endfunction

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t dut=%h model=%h", $time, dut_vec, exp_vec());
    end
  end

  // Activity monitor used by the directed checks.
  int en_cnt = 0, swap_cyc = 0, err_cnt = 0;
  bit seen_carry = 0;
  logic [7:0] prev_bcd = 8'h00;
  always @(negedge clk) begin
    if (count_en)    en_cnt++;
    if (bottle_swap) swap_cyc++;
    if (cfg_err)     err_cnt++;
    if (prev_bcd == 8'h09 && {bottle_tens, bottle_ones} == 8'h10) seen_carry = 1;
    prev_bcd = {bottle_tens, bottle_ones};
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start_btn = 1'b1; repeat (3) tick();
    start_btn = 1'b0; repeat (3) tick();
  endtask

  task automatic send_pill();
    pill = 1'b1; repeat (3) tick();
    pill = 1'b0; repeat (3) tick();
  endtask

  task automatic wait_for(input string name, input int code);
    for (int k = 0; k < 60; k++) begin
      if (int'(state) == code) break;
      tick();
    end
    check(name, int'(state), code);
  endtask

  task automatic do_reset();
    reset = 1'b1; repeat (2) tick();
    reset = 1'b0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    repeat (3) tick();
    check("reset_outputs", int'(dut_vec), 0);
    reset = 1'b0;
    tick();

    // Two bottles of 3 tablets each end the batch.
    target_tens = 4'd0; target_ones = 4'd3;
    press_start();
    check("t1_fill", int'(state), M_FILL);
    repeat (3) send_pill();
    check("t1_en_bottle1", en_cnt, 3);
    wait_for("t1_back_fill", M_FILL);
    check("t1_swap_len1", swap_cyc, 4);
    check("t1_done1", int'(bottles_done), 1);
    repeat (3) send_pill();
    wait_for("t1_done_state", M_DONE);
    check("t1_over", int'(over), 1);
    check("t1_allow", int'(allow_start), 0);
    check("t1_done2", int'(bottles_done), 2);
    check("t1_en_total", en_cnt, 6);
    check("t1_swap_len2", swap_cyc, 8);

    // Target 12 from DONE: BCD carry, then a pill during SWAP is dropped.
    target_tens = 4'd1; target_ones = 4'd2;
    base = en_cnt;
    press_start();
    check("t2_fill", int'(state), M_FILL);
    check("t2_done_clr", int'(bottles_done), 0);
    repeat (11) send_pill();
    pill = 1'b1; repeat (3) tick();
    pill = 1'b0; tick();
    check("t2_in_swap", int'(bottle_swap), 1);
    pill = 1'b1; repeat (3) tick();
    pill = 1'b0; repeat (3) tick();
    check("t2_en_12", en_cnt - base, 12);
    check("t2_carry", int'(seen_carry), 1);
    check("t2_cnt_clear", int'({bottle_tens, bottle_ones}), 0);

    // Pause after 2 tablets; pills while paused are ignored.
    do_reset();
    target_tens = 4'd0; target_ones = 4'd5;
    press_start();
    repeat (2) send_pill();
    stop_btn = 1'b1; repeat (4) tick();
    check("t3_pause", int'(state), M_PAUSE);
    check("t3_stop", int'(stop), 1);
    check("t3_valve", int'(valve_open), 0);
    base = en_cnt;
    repeat (3) send_pill();
    check("t3_no_en", en_cnt - base, 0);
    check("t3_cnt_held", int'(bottle_ones), 2);
    stop_btn = 1'b0;
    wait_for("t3_resume", M_FILL);
    repeat (3) send_pill();
    wait_for("t3_swap", M_SWAP);
    check("t3_done1", int'(bottles_done), 1);

    // Rejected targets.
    do_reset();
    target_tens = 4'd0; target_ones = 4'd0;
    base = err_cnt;
    press_start();
    check("t4_err00", err_cnt - base, 1);
    check("t4_idle00", int'(state), M_IDLE);
    check("t4_allow00", int'(allow_start), 0);
    target_tens = 4'd1; target_ones = 4'hA;
    press_start();
    check("t4_err1A", err_cnt - base, 2);
    check("t4_idle1A", int'(state), M_IDLE);

    // Asynchronous reset in the middle of a bottle.
    target_tens = 4'd0; target_ones = 4'd9;
    press_start();
    repeat (4) send_pill();
    check("t5_cnt4", int'({bottle_tens, bottle_ones}), 4);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("t5_async_clear", int'(dut_vec), 0);
    tick();
    reset = 1'b0;
    tick();
    target_tens = 4'd0; target_ones = 4'd2;
    press_start();
    repeat (2) send_pill();
    wait_for("t5_swap", M_SWAP);

    // Pill and stop arrive together: counted once, then PAUSE.
    wait_for("t6_fill", M_FILL);
    base = en_cnt;
    pill = 1'b1; stop_btn = 1'b1; repeat (3) tick();
    pill = 1'b0; repeat (3) tick();
    check("t6_en_once", en_cnt - base, 1);
    check("t6_pause", int'(state), M_PAUSE);
    stop_btn = 1'b0;
    wait_for("t6_resume", M_FILL);
    check("t6_cnt_kept", int'(bottle_ones), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tablet_fill_ctrl.md
Name: tablet_fill_ctrl

Overview:
- Sequencing controller for the tablet-counting line: fills one bottle at a time up to a BCD per-bottle target, swaps bottles, and stops after a batch quota.
- Drives the enable/stop/over controls of the downstream 3-digit BCD total-tablet counter.
- Issues that counter exactly one increment pulse per accepted tablet.
- Owns feeder valve and bottle-swap handshakes; sits between the tablet sensor/front-panel inputs and the total counter/display.

Parameters:
- MAX_BOTTLES, 10, bottles per batch (1..15); reaching it ends the batch.
- SWAP_CYC, 4, clock cycles bottle_swap stays high per swap (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- start_btn  in  1  async level; rising edge starts/restarts a batch
- stop_btn  in  1  async level; high requests pause
- pill  in  1  async tablet-sensor level; one tablet per rising edge
- target_tens  in  4  per-bottle target, BCD tens digit
- target_ones  in  4  per-bottle target, BCD ones digit
- count_en  out  1  one-cycle increment pulse to the total counter
- allow_start  out  1  high while a batch is active (FILL/SWAP/PAUSE)
- stop  out  1  high in PAUSE
- over  out  1  high in DONE
- valve_open  out  1  feeder open, high only in FILL
- bottle_swap  out  1  high during SWAP
- bottle_tens  out  4  current-bottle count, BCD tens
- bottle_ones  out  4  current-bottle count, BCD ones
- bottles_done  out  4  binary bottles completed this batch
- cfg_err  out  1  one-cycle pulse when a start is rejected
- state  out  3  encoded FSM state

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk. All outputs are registered; every output resets to 0 and state resets to IDLE.
- Input conditioning: start_btn, stop_btn and pill each pass through 2 synchronising flops.
  - Edge detect on start_btn and pill: sync2 & ~sync3.
  - stop_btn is used as the level sync2.
- State encoding: IDLE=0, FILL=1, SWAP=2, PAUSE=3, DONE=4. Other codes go to IDLE.
- IDLE, start edge:
  - Latch target. If target is 00 or either digit is >9, pulse cfg_err and stay in IDLE.
  - Otherwise clear bottle count and bottles_done, then go to FILL.
- FILL:
  - A pill edge asserts count_en for the next cycle and increments the bottle BCD count in the same edge. Ones digit wraps 9->0 with carry into tens.
  - Latency from pill pin rising to count_en high is 3 clocks.
  - When the updated count equals the target, go to SWAP on the following edge. The target-reaching tablet is counted.
  - If stop is high and the target is not reached, go to PAUSE. A pill edge coincident with stop is still counted.
- SWAP:
  - On entry, increment bottles_done, clear the bottle count and assert bottle_swap for SWAP_CYC cycles.
  - Pill edges are ignored: no count_en.
  - At the end of the swap:
    - if bottles_done==MAX_BOTTLES, go to DONE;
    - else if stop is high, go to PAUSE;
    - else go to FILL.
  - A stop during SWAP never shortens the swap.
- PAUSE: stop=1, valve closed, pill edges ignored. When stop goes low, return to FILL with the bottle count preserved.
- DONE: over=1, allow_start=0. Counts are held for display. A start edge behaves as in IDLE, including target validation.
- Start edge in FILL/SWAP/PAUSE: ignored.
- Reset mid-batch: immediate return to IDLE with all counts cleared. In-flight synchroniser contents are discarded.
- Never assert count_en outside FILL, and never on more than one cycle per edge.

Decomposition:
- Shared package tablet_pkg: state encoding constants, the BCD digit type (4 bits), and the BCD_MAX=9 constant.
- One natural sub-module, edge_sync: 2-flop synchroniser plus rising-edge detector. Instantiate it 3 times, with a level output used for stop.
- The BCD bottle counter stays inline.

Test Plan:
- Target 0x03, MAX_BOTTLES=2, 3 pills then 3 pills:
  - 3 count_en pulses per bottle;
  - bottle_swap high 4 cycles after the 3rd pill each time;
  - bottles_done 1 then 2;
  - over=1 after the second swap; total count_en = 6.
- Target 0x12, 12 pills: bottle count steps 09->10 with a correct BCD carry, then SWAP. The 13th pill, sent during SWAP, produces no count_en.
- Target 0x05, stop raised after 2 pills:
  - state=PAUSE, stop=1, valve_open=0;
  - 3 pills sent while paused are ignored;
  - release stop, then 3 pills -> SWAP.
- Start edge with target 0x00 or 0x1A: cfg_err pulses once, state stays IDLE, allow_start=0.
- Reset asserted mid-FILL with bottle count 0x04: all outputs 0 immediately and asynchronously. After release, a start edge with target 0x02 followed by 2 pills reaches SWAP.
- Pill edge on the same cycle stop rises in FILL: count_en fires once, then the FSM enters PAUSE.
